// File: rtl/slink_rx_packet_buffer.sv
// rtl/slink_rx_packet_buffer.sv - store-and-forward packet buffer for one routed RX channel.
// Optional feature macro: SLINK_RX_PKT_BUF_CRC_DROP_EN (drop CRC-failed packets instead of flagging them).
module slink_rx_packet_buffer #(
    parameter int         DATA_WIDTH      = 64,
    parameter int         DEPTH           = 32,
    parameter int         HDR_DEPTH       = 8,
    parameter logic [7:0] LONG_PKT_MIN_ID = 8'h30
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_sop,
    input  logic [7:0]            rx_data_id,
    input  logic [15:0]           rx_word_count,
    input  logic [DATA_WIDTH-1:0] rx_app_data,
    input  logic                  rx_valid,
    input  logic                  rx_crc_corrupted,
    input  logic                  clr_counts,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [7:0]            out_data_id,
    output logic [15:0]           out_word_count,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_crc_err,
    output logic [7:0]            drop_err_count,
    output logic [7:0]            drop_ovf_count
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int HAW   = $clog2(HDR_DEPTH);
    localparam int HW    = 8 + 16 + 17 + 1;
    localparam logic [AW:0]  PTR_ONE  = 1;
    localparam logic [HAW:0] HPTR_ONE = 1;

`ifdef SLINK_RX_PKT_BUF_CRC_DROP_EN
    localparam logic CRC_DROP = 1'b1;
`else
    localparam logic CRC_DROP = 1'b0;
`endif

    typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_SOP, RD_BODY} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [HW-1:0]         hdr_mem [HDR_DEPTH];
    logic [AW:0]           wr_ptr, wr_ptr_commit, rd_ptr, wr_base, wr_ptr_nxt;
    logic [HAW:0]          hdr_wr_ptr, hdr_rd_ptr;
    wr_state_t             wr_state, wr_state_nxt;
    rd_state_t             rd_state, rd_state_nxt;
    logic [16:0]           beats_left, beats_left_nxt;
    logic [7:0]            pkt_id;
    logic [15:0]           pkt_wc;
    logic [16:0]           pkt_beats;

    // ---------------- write side decode ----------------
    logic        sop_beat, is_long, trunc, data_full, hdr_full, sop_drop, body_beat, body_last;
    logic [16:0] wc_round, wc_beats, sop_beats;
    logic [7:0]  fin_id;
    logic [15:0] fin_wc;
    logic [16:0] fin_beats;

    assign sop_beat  = rx_valid && rx_sop;
    assign is_long   = rx_data_id >= LONG_PKT_MIN_ID;
    assign wc_round  = {1'b0, rx_word_count} + 17'(BYTES - 1);
    assign wc_beats  = wc_round / 17'(BYTES);
    assign sop_beats = (!is_long || wc_beats == 17'd0) ? 17'd1 : wc_beats;
    assign trunc     = sop_beat && wr_state == WR_PKT;
    // A truncating SOP rewinds first, so its own full check sees the freed space.
    assign wr_base   = trunc ? wr_ptr_commit : wr_ptr;
    assign data_full = (wr_base[AW] != rd_ptr[AW]) && (wr_base[AW-1:0] == rd_ptr[AW-1:0]);
    assign hdr_full  = (hdr_wr_ptr[HAW] != hdr_rd_ptr[HAW]) &&
                       (hdr_wr_ptr[HAW-1:0] == hdr_rd_ptr[HAW-1:0]);
    assign sop_drop  = sop_beat && (hdr_full || (is_long && data_full));
    assign body_beat = rx_valid && !rx_sop && wr_state != WR_IDLE;
    assign body_last = beats_left == 17'd1;
    assign fin_id    = sop_beat ? rx_data_id    : pkt_id;
    assign fin_wc    = sop_beat ? rx_word_count : pkt_wc;
    assign fin_beats = sop_beat ? sop_beats     : pkt_beats;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_state <= WR_IDLE;
        else       wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        if (sop_beat) begin
            if (is_long && sop_beats > 17'd1) wr_state_nxt = sop_drop ? WR_DROP : WR_PKT;
            else                              wr_state_nxt = WR_IDLE;
        end else if (body_beat) begin
            if (body_last)                               wr_state_nxt = WR_IDLE;
            else if (wr_state == WR_PKT && data_full)    wr_state_nxt = WR_DROP;
        end
    end

    logic          mem_we, commit, hdr_push, load_pkt, fin, ovf_inc;
    logic [1:0]    err_add;
    logic [HW-1:0] hdr_din;

    always_comb begin
        mem_we         = 1'b0;
        commit         = 1'b0;
        hdr_push       = 1'b0;
        load_pkt       = 1'b0;
        fin            = 1'b0;
        ovf_inc        = 1'b0;
        err_add        = 2'd0;
        hdr_din        = '0;
        wr_ptr_nxt     = wr_ptr;
        beats_left_nxt = beats_left;
        if (trunc) begin
            err_add    = 2'd1;
            wr_ptr_nxt = wr_ptr_commit;
        end
        if (sop_beat) begin
            load_pkt       = 1'b1;
            beats_left_nxt = sop_beats - 17'd1;
            if (sop_drop) begin
                ovf_inc    = 1'b1;
                wr_ptr_nxt = wr_base;
            end else if (!is_long) begin
                hdr_push = 1'b1;
                hdr_din  = {rx_data_id, rx_word_count, 17'd0, 1'b0};
            end else begin
                mem_we = 1'b1;
                if (sop_beats == 17'd1) fin = 1'b1;
                else                    wr_ptr_nxt = wr_base + PTR_ONE;
            end
        end else if (body_beat) begin
            beats_left_nxt = beats_left - 17'd1;
            if (wr_state == WR_PKT) begin
                if (data_full) begin
                    ovf_inc    = 1'b1;
                    wr_ptr_nxt = wr_ptr_commit;
                end else begin
                    mem_we = 1'b1;
                    if (body_last) fin = 1'b1;
                    else           wr_ptr_nxt = wr_ptr + PTR_ONE;
                end
            end
        end
        if (fin) begin
            if (rx_crc_corrupted && CRC_DROP) begin
                wr_ptr_nxt = wr_ptr_commit;
                err_add    = err_add + 2'd1;
            end else begin
                wr_ptr_nxt = wr_base + PTR_ONE;
                commit     = 1'b1;
                hdr_push   = 1'b1;
                hdr_din    = {fin_id, fin_wc, fin_beats, rx_crc_corrupted};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)   mem[wr_base[AW-1:0]]         <= rx_app_data;
        if (hdr_push) hdr_mem[hdr_wr_ptr[HAW-1:0]] <= hdr_din;
    end

    logic [8:0] err_sum;
    assign err_sum = {1'b0, drop_err_count} + {7'd0, err_add};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            wr_ptr_commit  <= '0;
            hdr_wr_ptr     <= '0;
            beats_left     <= '0;
            pkt_id         <= '0;
            pkt_wc         <= '0;
            pkt_beats      <= '0;
            drop_err_count <= '0;
            drop_ovf_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            beats_left <= beats_left_nxt;
            if (commit)   wr_ptr_commit <= wr_ptr_nxt;
            if (hdr_push) hdr_wr_ptr    <= hdr_wr_ptr + HPTR_ONE;
            if (load_pkt) begin
                pkt_id    <= rx_data_id;
                pkt_wc    <= rx_word_count;
                pkt_beats <= sop_beats;
            end
            if (clr_counts) begin
                drop_err_count <= '0;
                drop_ovf_count <= '0;
            end else begin
                drop_err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
                if (ovf_inc && drop_ovf_count != 8'hFF) drop_ovf_count <= drop_ovf_count + 8'd1;
            end
        end
    end

    // ---------------- read side ----------------
    logic        hdr_avail, accept, eop_cur, hdr_pop, cur_crc;
    logic [16:0] cur_beats, rd_left;
    logic [7:0]  hq_id;
    logic [15:0] hq_wc;
    logic [16:0] hq_beats;
    logic        hq_crc;

    assign {hq_id, hq_wc, hq_beats, hq_crc} = hdr_mem[hdr_rd_ptr[HAW-1:0]];
    assign hdr_avail = hdr_wr_ptr != hdr_rd_ptr;
    assign accept    = out_valid && out_ready;
    assign eop_cur   = rd_left <= 17'd1;
    assign hdr_pop   = hdr_avail && (rd_state == RD_IDLE || (accept && eop_cur));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_state <= RD_IDLE;
        else       rd_state <= rd_state_nxt;
    end

    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            RD_IDLE: if (hdr_avail) rd_state_nxt = RD_SOP;
            RD_SOP, RD_BODY: begin
                if (accept) begin
                    if (eop_cur) rd_state_nxt = hdr_avail ? RD_SOP : RD_IDLE;
                    else         rd_state_nxt = RD_BODY;
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    // Short packets carry no data beats, so they read zero instead of the FIFO.
    always_comb begin
        out_valid = rd_state != RD_IDLE;
        out_sop   = rd_state == RD_SOP;
        out_eop   = out_valid && eop_cur;
        out_data  = (out_valid && cur_beats != 17'd0) ? mem[rd_ptr[AW-1:0]] : '0;
    end

    assign out_crc_err = cur_crc & ~CRC_DROP;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr         <= '0;
            hdr_rd_ptr     <= '0;
            out_data_id    <= '0;
            out_word_count <= '0;
            cur_beats      <= '0;
            rd_left        <= '0;
            cur_crc        <= 1'b0;
        end else begin
            if (hdr_pop) begin
                out_data_id    <= hq_id;
                out_word_count <= hq_wc;
                cur_beats      <= hq_beats;
                rd_left        <= hq_beats;
                cur_crc        <= hq_crc;
                hdr_rd_ptr     <= hdr_rd_ptr + HPTR_ONE;
            end else if (accept && !eop_cur) begin
                rd_left <= rd_left - 17'd1;
            end
            if (accept && cur_beats != 17'd0) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule
